// File: rtl/morse_key_decoder.sv
// Morse key receiver: synchronizes a raw key line, times marks and spaces in
// UNIT_TICKS units, decodes each character and offers it on a valid/ready port.
module morse_key_decoder #(
  parameter int UNIT_TICKS = 16,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_key_in,
  output logic [7:0] o_out_ascii,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic       o_drop
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MARK = 2'd1,
    S_GAP  = 2'd2,
    S_WORD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TWO_U   = CNT_W'(2 * UNIT_TICKS);
  localparam logic [CNT_W-1:0] FIVE_U  = CNT_W'(5 * UNIT_TICKS);
  localparam logic [CNT_W-1:0] DUR_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DUR_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic             r_sync1;
  logic             r_key_s;
  logic             r_key_d;
  logic [CNT_W-1:0] r_dur;
  logic [3:0]       r_cnt;
  logic [7:0]       r_buf;
  logic             r_word_pending;

  logic             w_edge;
  logic             w_is_dash;
  logic [7:0]       w_decoded;
  logic             w_emit;
  logic [7:0]       w_emit_byte;

  // Elements are rebuilt first-element-first so table entries read like Morse.
  function automatic logic [7:0] decode_char(input logic [3:0] cnt, input logic [7:0] elems);
    logic [7:0] rev;
    logic [7:0] code;
    rev  = {<<{elems}};
    code = rev >> (4'd8 - cnt);
    case ({cnt, code})
      {4'd2, 8'b01}:     decode_char = 8'h41;
      {4'd4, 8'b1000}:   decode_char = 8'h42;
      {4'd4, 8'b1010}:   decode_char = 8'h43;
      {4'd3, 8'b100}:    decode_char = 8'h44;
      {4'd1, 8'b0}:      decode_char = 8'h45;
      {4'd4, 8'b0010}:   decode_char = 8'h46;
      {4'd3, 8'b110}:    decode_char = 8'h47;
      {4'd4, 8'b0000}:   decode_char = 8'h48;
      {4'd2, 8'b00}:     decode_char = 8'h49;
      {4'd4, 8'b0111}:   decode_char = 8'h4A;
      {4'd3, 8'b101}:    decode_char = 8'h4B;
      {4'd4, 8'b0100}:   decode_char = 8'h4C;
      {4'd2, 8'b11}:     decode_char = 8'h4D;
      {4'd2, 8'b10}:     decode_char = 8'h4E;
      {4'd3, 8'b111}:    decode_char = 8'h4F;
      {4'd4, 8'b0110}:   decode_char = 8'h50;
      {4'd4, 8'b1101}:   decode_char = 8'h51;
      {4'd3, 8'b010}:    decode_char = 8'h52;
      {4'd3, 8'b000}:    decode_char = 8'h53;
      {4'd1, 8'b1}:      decode_char = 8'h54;
      {4'd3, 8'b001}:    decode_char = 8'h55;
      {4'd4, 8'b0001}:   decode_char = 8'h56;
      {4'd3, 8'b011}:    decode_char = 8'h57;
      {4'd4, 8'b1001}:   decode_char = 8'h58;
      {4'd4, 8'b1011}:   decode_char = 8'h59;
      {4'd4, 8'b1100}:   decode_char = 8'h5A;
      {4'd5, 8'b11111}:  decode_char = 8'h30;
      {4'd5, 8'b01111}:  decode_char = 8'h31;
      {4'd5, 8'b00111}:  decode_char = 8'h32;
      {4'd5, 8'b00011}:  decode_char = 8'h33;
      {4'd5, 8'b00001}:  decode_char = 8'h34;
      {4'd5, 8'b00000}:  decode_char = 8'h35;
      {4'd5, 8'b10000}:  decode_char = 8'h36;
      {4'd5, 8'b11000}:  decode_char = 8'h37;
      {4'd5, 8'b11100}:  decode_char = 8'h38;
      {4'd5, 8'b11110}:  decode_char = 8'h39;
      {4'd6, 8'b010101}: decode_char = 8'h2E;
      {4'd6, 8'b110011}: decode_char = 8'h2C;
      {4'd6, 8'b111000}: decode_char = 8'h3A;
      {4'd6, 8'b001100}: decode_char = 8'h3F;
      {4'd6, 8'b011110}: decode_char = 8'h27;
      {4'd6, 8'b100001}: decode_char = 8'h2D;
      {4'd5, 8'b10010}:  decode_char = 8'h2F;
      {4'd5, 8'b10110}:  decode_char = 8'h28;
      {4'd6, 8'b101101}: decode_char = 8'h29;
      {4'd6, 8'b010010}: decode_char = 8'h22;
      {4'd5, 8'b10001}:  decode_char = 8'h3D;
      {4'd5, 8'b01010}:  decode_char = 8'h2B;
      {4'd6, 8'b011010}: decode_char = 8'h40;
      {4'd8, 8'b0}:      decode_char = 8'h08;
      default:           decode_char = 8'h2A;
    endcase
  endfunction

  assign w_edge    = r_key_s ^ r_key_d;
  assign w_is_dash = (r_dur >= TWO_U);
  assign w_decoded = decode_char(r_cnt, r_buf);

  // Key synchronizer plus one extra stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_key_s <= 1'b0;
      r_key_d <= 1'b0;
    end else begin
      r_sync1 <= i_key_in;
      r_key_s <= r_sync1;
      r_key_d <= r_key_s;
    end
  end

  // dur restarts at 1 on an edge so that at the next edge it equals the level's length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dur <= '0;
    end else if (w_edge) begin
      r_dur <= DUR_ONE;
    end else if (r_dur != DUR_MAX) begin
      r_dur <= r_dur + DUR_ONE;
    end else begin
      r_dur <= r_dur;
    end
  end

  // Emit request and byte for the current cycle.
  always_comb begin
    w_emit      = 1'b0;
    w_emit_byte = 8'h00;
    case (r_state)
      S_GAP: begin
        if (r_dur == TWO_U) begin
          w_emit      = 1'b1;
          w_emit_byte = w_decoded;
        end else begin
          w_emit      = 1'b0;
          w_emit_byte = 8'h00;
        end
      end
      S_WORD: begin
        if ((r_dur == FIVE_U) && r_word_pending) begin
          w_emit      = 1'b1;
          w_emit_byte = 8'h20;
        end else begin
          w_emit      = 1'b0;
          w_emit_byte = 8'h00;
        end
      end
      default: begin
        w_emit      = 1'b0;
        w_emit_byte = 8'h00;
      end
    endcase
  end

  // Character FSM; a gap ending exactly on the threshold still emits, then follows the key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= 4'd0;
      r_buf          <= 8'h00;
      r_word_pending <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_key_s) r_state <= S_MARK;
          else         r_state <= S_IDLE;
        end
        S_MARK: begin
          if (w_edge) begin
            if (r_cnt < 4'd8) r_buf[r_cnt[2:0]] <= w_is_dash;
            if (r_cnt != 4'd9) r_cnt <= r_cnt + 4'd1;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_dur == TWO_U) begin
            r_cnt          <= 4'd0;
            r_buf          <= 8'h00;
            r_word_pending <= 1'b1;
            r_state        <= r_key_s ? S_MARK : S_WORD;
          end else if (w_edge) begin
            r_state <= S_MARK;
          end
        end
        S_WORD: begin
          if ((r_dur == FIVE_U) && r_word_pending) begin
            r_word_pending <= 1'b0;
            r_state        <= r_key_s ? S_MARK : S_IDLE;
          end else if (w_edge) begin
            r_state <= S_MARK;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output holding register with overflow drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_out_ascii <= 8'h00;
      o_out_valid <= 1'b0;
      o_drop      <= 1'b0;
    end else if (w_emit) begin
      if (!o_out_valid || i_out_ready) begin
        o_out_ascii <= w_emit_byte;
        o_out_valid <= 1'b1;
        o_drop      <= 1'b0;
      end else begin
        o_drop <= 1'b1;
      end
    end else begin
      o_drop <= 1'b0;
      if (i_out_ready) o_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed bench for morse_key_decoder at UNIT_TICKS=4: keys characters and
// compares the received byte stream and drop pulses with hand-computed values.
module tb_morse_key_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] ascii;
  logic       valid;
  logic       drop;

  int         n_checks = 0;
  int         n_fail = 0;
  int         n_drops = 0;
  int         drops_base = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  morse_key_decoder #(.UNIT_TICKS(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_key_in   (key),
    .o_out_ascii(ascii),
    .o_out_valid(valid),
    .i_out_ready(ready),
    .o_drop     (drop)
  );

  // Record each accepted byte and each drop pulse.
  always @(negedge clk) begin
    if (valid && ready) rx_q.push_back(ascii);
    if (drop) n_drops <= n_drops + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    key = lvl;
    repeat (n) @(negedge clk);
  endtask

  // '.' = 4-cycle mark, '-' = 12-cycle mark, 4-cycle gaps inside the character.
  task automatic send(input string pat);
    for (int i = 0; i < pat.len(); i++) begin
      hold(1'b1, (pat[i] == "-") ? 12 : 4);
      if (i != pat.len() - 1) hold(1'b0, 4);
    end
    key = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ascii", ascii, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_drop", drop, 1'b0);
    rst_n = 1'b1;
    hold(1'b0, 4);

    // 'A' then a word space
    rx_q.delete();
    hold(1'b1, 4); hold(1'b0, 4); hold(1'b1, 12); hold(1'b0, 20);
    hold(1'b0, 40);
    check("a_count", rx_q.size(), 2);
    check("a_byte0", rx_q[0], 8'h41);
    check("a_byte1", rx_q[1], 8'h20);

    // SOS and a long idle: a single trailing space
    rx_q.delete();
    send("..."); hold(1'b0, 12);
    send("---"); hold(1'b0, 12);
    send("..."); hold(1'b0, 200);
    check("sos_count", rx_q.size(), 4);
    check("sos_byte0", rx_q[0], 8'h53);
    check("sos_byte1", rx_q[1], 8'h4F);
    check("sos_byte2", rx_q[2], 8'h53);
    check("sos_byte3", rx_q[3], 8'h20);

    // Too long, error prosign, unmatched pattern
    rx_q.delete();
    send("........."); hold(1'b0, 12);
    send("........");  hold(1'b0, 12);
    send("..--");      hold(1'b0, 40);
    check("odd_count", rx_q.size(), 4);
    check("nine_dots", rx_q[0], 8'h2A);
    check("eight_dots", rx_q[1], 8'h08);
    check("unmatched", rx_q[2], 8'h2A);
    check("odd_space", rx_q[3], 8'h20);

    // Back-pressure: 'E' held, 'T' dropped
    rx_q.delete();
    ready = 1'b0;
    drops_base = n_drops;
    send("."); hold(1'b0, 12);
    send("-"); hold(1'b0, 12);
    check("bp_ascii", ascii, 8'h45);
    check("bp_valid", valid, 1'b1);
    check("bp_drops", n_drops - drops_base, 1);
    @(posedge clk);
    #2 ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid_after", valid, 1'b0);
    hold(1'b0, 30);
    check("bp_count", rx_q.size(), 2);
    check("bp_byte0", rx_q[0], 8'h45);
    check("bp_byte1", rx_q[1], 8'h20);
    check("bp_drops_total", n_drops - drops_base, 1);

    // Reset in the middle of a dash after two dots
    rx_q.delete();
    hold(1'b1, 4); hold(1'b0, 4); hold(1'b1, 4); hold(1'b0, 4); hold(1'b1, 6);
    rst_n = 1'b0;
    key = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_valid", valid, 1'b0);
    rst_n = 1'b1;
    hold(1'b0, 40);
    check("post_rst_empty", rx_q.size(), 0);
    send("-"); hold(1'b0, 40);
    check("rst_count", rx_q.size(), 2);
    check("rst_byte0", rx_q[0], 8'h54);
    check("rst_byte1", rx_q[1], 8'h20);

    // Dot/dash boundary: 7 cycles is a dot, 8 cycles a dash
    rx_q.delete();
    hold(1'b1, 7); hold(1'b0, 12);
    hold(1'b1, 8); hold(1'b0, 40);
    check("bnd_count", rx_q.size(), 3);
    check("bnd_mark7", rx_q[0], 8'h45);
    check("bnd_mark8", rx_q[1], 8'h54);
    check("bnd_space", rx_q[2], 8'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_key_decoder.md
Name: morse_key_decoder

Overview:
- Converts a live Morse key line into a stream of ASCII bytes. It is the receive-side counterpart of the ASCII-to-Morse lookup used on the transmit path.
- Samples the key, measures mark and space durations in units of UNIT_TICKS clock cycles, and classifies each mark as a dot or a dash.
- Collects the elements of one character, decodes them to ASCII, and presents each byte on a valid/ready output port.
- Sits between the key input pad and the UART/text FIFO.

Parameters:
- UNIT_TICKS, 16: clock cycles per Morse time unit (one dot length); must be >= 2.
- CNT_W, 8: duration counter width; must satisfy 2^CNT_W > 5*UNIT_TICKS.

Ports:
- clk  in  1  the block's single clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- key_in  in  1  raw key level, 1 = key down (mark); asynchronous to clk.
- out_ascii  out  8  decoded character.
- out_valid  out  1  out_ascii holds a character.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- drop  out  1  one-cycle pulse: a character was lost because the output register was still occupied.

Behaviour:
- Reset (asynchronous, rst_n=0): out_ascii=0x00, out_valid=0, drop=0, state=IDLE, element buffer empty, word_pending=0, synchronizer flops cleared to 0.
- Input path: key_in passes through a 2-flop synchronizer, giving key_s. All timing below counts cycles of key_s.
- Duration counter dur: cleared on every key_s edge, otherwise increments each cycle, saturating at all-ones.
- Element buffer: up to 8 elements, stored in arrival order, 1 = dash. The element count saturates at 9; count 9 means "too long".
- States:
  - IDLE: no elements pending, key up. On key_s=1 -> MARK.
  - MARK: key down. On key_s falling, classify with dur taken before the clear: dur < 2*UNIT_TICKS -> dot, else dash. Append the element, then -> GAP.
  - GAP: key up, elements pending.
    - key_s rising before dur reaches 2*UNIT_TICKS -> MARK (intra-character gap).
    - dur == 2*UNIT_TICKS -> emit the decoded character, clear the buffer, set word_pending=1, -> WORD.
  - WORD: key up, buffer empty.
    - key_s rising -> MARK.
    - dur == 5*UNIT_TICKS with word_pending=1 -> emit 0x20, clear word_pending, -> IDLE.
  - In IDLE a long silence emits nothing, so there is never more than one space per word.
- Emit rule:
  - If out_valid=0, or out_ready=1 in the same cycle, load out_ascii and set out_valid=1 from the next cycle.
  - Otherwise keep the old byte, discard the new one, and pulse drop for one cycle.
  - out_valid clears on handshake when no new load occurs.
- Latency: out_valid rises 1 cycle after the emit cycle. The emit cycle is 2 sync cycles + 2*UNIT_TICKS after key_in falls on the final element.
- Decode: codes are the international Morse table, output as uppercase ASCII.
  - A-Z: 0x41-0x5A. 0-9: 0x30-0x39.
  - Punctuation: . , : ? ' - / ( ) " = + @, mapping to 0x2E 0x2C 0x3A 0x3F 0x27 0x2D 0x2F 0x28 0x29 0x22 0x3D 0x2B 0x40.
  - Eight dots (error prosign) -> 0x08.
  - Any unmatched pattern, or count 9 -> 0x2A ('*').
  - The lookup is combinational from count and buffer; the result is registered at emit.
- A mark longer than the saturation value is still a dash. Zero-length marks cannot occur after the synchronizer.
- A reset asserted mid-character discards the partial buffer; nothing is emitted.

Test Plan:
- UNIT_TICKS=4, out_ready=1. key: mark 4, space 4, mark 12, then space 20 -> one byte 0x41 ('A'), then 0x20 at the 5-unit mark; exactly 2 handshakes.
- Send "SOS", char gaps 12 cycles, then a long idle -> bytes 0x53 0x4F 0x53 0x20; no extra spaces during 200 idle cycles.
- Nine dots then a char gap -> 0x2A. Eight dots -> 0x08. Pattern ..-- -> 0x2A.
- out_ready=0; send "E" then "T" -> out_ascii stays 0x45, drop pulses once for 'T'. Raise out_ready -> 0x45 is accepted and out_valid drops.
- Assert rst_n=0 for 3 cycles in the middle of a dash after two dots, release, then send "T" -> only 0x54 then 0x20; no partial character.
- Mark lengths 7 vs 8 cycles (UNIT_TICKS=4) -> 'E'(0x45) vs 'T'(0x54), confirming the dot/dash boundary at exactly 2 units.
